// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch stage with a prefetch queue and PC redirect.
//            Optional performance counters enabled by IFETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int                       MP_DATA_WIDTH = 32,
  parameter int                       MP_FIFO_DEPTH = 4,
  parameter logic [MP_DATA_WIDTH-1:0] MP_RESET_PC   = '0
) (
  input  logic                     iclk,
  input  logic                     irst,
  output logic [MP_DATA_WIDTH-1:0] oimem_addr,
  input  logic [MP_DATA_WIDTH-1:0] iimem_rdata,
  input  logic                     iredirect,
  input  logic [MP_DATA_WIDTH-1:0] iredirect_pc,
  output logic                     ovalid,
  input  logic                     iready,
  output logic [MP_DATA_WIDTH-1:0] oinstr,
  output logic [MP_DATA_WIDTH-1:0] opc,
  output logic [MP_DATA_WIDTH-1:0] opc_plus4,
  output logic [31:0]              ofetch_cnt,
  output logic [31:0]              oflush_cnt
);

  localparam int                       c_ptr_w = $clog2(MP_FIFO_DEPTH);
  localparam int                       c_cnt_w = c_ptr_w + 1;
  localparam logic [MP_DATA_WIDTH-1:0] c_four  = MP_DATA_WIDTH'(4);

  logic [MP_DATA_WIDTH-1:0] r_pc;
  logic [MP_DATA_WIDTH-1:0] r_q_pc    [MP_FIFO_DEPTH];
  logic [MP_DATA_WIDTH-1:0] r_q_instr [MP_FIFO_DEPTH];
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_cnt_w-1:0]       r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = (r_count != '0) && iready && !iredirect;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign w_push = !iredirect && ((r_count < c_cnt_w'(MP_FIFO_DEPTH)) || w_pop);

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_pc     <= MP_RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MP_FIFO_DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (iredirect) begin
      r_pc     <= {iredirect_pc[MP_DATA_WIDTH-1:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]    <= r_pc;
        r_q_instr[r_wr_ptr] <= iimem_rdata;
        r_wr_ptr            <= r_wr_ptr + c_ptr_w'(1);
        r_pc                <= r_pc + c_four;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign oimem_addr = r_pc;
  assign ovalid     = (r_count != '0);
  assign oinstr     = r_q_instr[r_rd_ptr];
  assign opc        = r_q_pc[r_rd_ptr];
  assign opc_plus4  = r_q_pc[r_rd_ptr] + c_four;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (iredirect) begin
        r_flush_cnt <= r_flush_cnt + 32'(r_count);
      end
    end
  end

  assign ofetch_cnt = r_fetch_cnt;
  assign oflush_cnt = r_flush_cnt;
`else
  assign ofetch_cnt = 32'h0;
  assign oflush_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch (directed table, hand
//            sequences and random stimulus against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .iclk         (clk),
    .irst         (rst),
    .oimem_addr   (imem_addr),
    .iimem_rdata  (imem_rdata),
    .iredirect    (redirect),
    .iredirect_pc (redirect_pc),
    .ovalid       (valid),
    .iready       (ready),
    .oinstr       (instr),
    .opc          (pc),
    .opc_plus4    (pc_plus4),
    .ofetch_cnt   (fetch_cnt),
    .oflush_cnt   (flush_cnt)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: in-order queue of fetched {pc, instr}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] mfetch;
  logic [31:0] mflush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    bit do_pop;
    if (r) begin
      mq.delete();
      mpc    = 32'h0;
      mfetch = 32'h0;
      mflush = 32'h0;
    end else if (rd) begin
      mflush = mflush + 32'(mq.size());
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (mq.size() < 4) begin
        mq.push_back('{pc: mpc, instr: mem_word(mpc)});
        mpc    = mpc + 32'd4;
        mfetch = mfetch + 32'd1;
      end
    end
  endtask

  task automatic model_check();
    chk("valid", {31'b0, valid}, {31'b0, mq.size() != 0});
    chk("imem_addr", imem_addr, mpc);
    if (mq.size() != 0) begin
      chk("opc", pc, mq[0].pc);
      chk("oinstr", instr, mq[0].instr);
      chk("opc_plus4", pc_plus4, mq[0].pc + 32'd4);
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, mfetch);
    chk("flush_cnt", flush_cnt, mflush);
`else
    chk("fetch_cnt", fetch_cnt, 32'h0);
    chk("flush_cnt", flush_cnt, 32'h0);
`endif
  endtask

  // Inputs change at the falling edge; outputs checked at the next falling edge.
  task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    ready       = rdy;
    @(posedge clk);
    model_step(r, rd, rpc, rdy);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] f0;
    logic [31:0] fl0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 32'h0000_0008};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 32'h0000_0008};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0014, 32'h0000_0008};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0018, 32'h0000_0008};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0018, 32'h0000_0008};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_001C, 32'h0000_000C};
    vecs[9]  = '{1'b0, 1'b1, 32'h47,       1'b1, 1'b0, 32'h0000_0044, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0048, 32'h0000_0044};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 32'h0000_0000};
    vecs[15] = '{1'b1, 1'b1, 32'h100,      1'b1, 1'b0, 32'h0000_0000, 32'h0};

    mq.delete();
    mpc    = 32'h0;
    mfetch = 32'h0;
    mflush = 32'h0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].rst, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d opc", i), pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d opc_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
      end
      if (i == 0) begin
        chk("reset oinstr", instr, 32'h0);
        chk("reset opc", pc, 32'h0);
        chk("reset opc_plus4", pc_plus4, 32'h4);
        chk("reset fetch_cnt", fetch_cnt, 32'h0);
        chk("reset flush_cnt", flush_cnt, 32'h0);
      end
    end

    // Stall until full, then drain back-to-back with no bubble.
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall addr", imem_addr, 32'h10);
    for (int k = 0; k < 5; k++) begin
      chk("drain valid", {31'b0, valid}, 32'h1);
      chk("drain opc", pc, 32'(k * 4));
      chk("drain oinstr", instr, mem_word(32'(k * 4)));
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Full queue with ready held: one push per pop.
    f0 = mfetch;
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IFETCH_PERF_CNT_EN
    chk("steady fetch_cnt", fetch_cnt, f0 + 32'd20);
`else
    chk("steady fetch_cnt", fetch_cnt, 32'h0);
`endif

    // Redirect with a full queue discards all four entries.
    fl0 = mflush;
    cycle(1'b0, 1'b1, 32'h47, 1'b1);
    chk("redir addr", imem_addr, 32'h44);
    chk("redir valid", {31'b0, valid}, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("redir flush_cnt", flush_cnt, fl0 + 32'd4);
`else
    chk("redir flush_cnt", flush_cnt, 32'h0);
`endif
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir opc", pc, 32'h44);

    // Held redirect keeps the queue empty and tracks the current target.
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    cycle(1'b0, 1'b1, 32'h303, 1'b0);
    chk("held redir addr", imem_addr, 32'h300);
    chk("held redir valid", {31'b0, valid}, 32'h0);

    for (int k = 0; k < 400; k++) begin
      logic        r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 65);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(r, rd, rpc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
